mem_bus_master: RTL and testbench
=================================

# mem_bus_master

Parametrised Avalon-MM master sitting between the multi-cycle MIPS core's control path and the external memory bus. Accepts one load/store request at a time and drives `address`/`read`/`write`/`byteenable`/`writedata` until the slave drops `waitrequest`. Provides byte/half/word lane steering and sign/zero extension, a stall to the core FSM, and a bounded-wait timeout with an error flag.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, width of core-side and bus-side byte address.
- `TIMEOUT`, 256, maximum `waitrequest` cycles before abort. 0 disables the timeout.

Ports:
- `clk` in 1: the single clock.
- `reset` in 1: asynchronous, active-high.
- `req_i` in 1: access request from the core, sampled in IDLE only.
- `wen_i` in 1: 1 = store, 0 = load.
- `size_i` in 2: 00 byte, 01 half, 10 word; 11 is treated as word.
- `signed_i` in 1: load sign-extends when 1, zero-extends when 0.
- `addr_i` in ADDR_WIDTH: byte address.
- `wdata_i` in 32: store data, right-justified.
- `rdata_o` out 32: extended load result.
- `stall_o` out 1: core must hold its FSM.
- `done_o` out 1: one-cycle completion pulse.
- `err_o` out 1: qualifies `done_o`; access failed.
- `address` out ADDR_WIDTH: word-aligned bus address.
- `write`, `read` out 1: Avalon strobes.
- `waitrequest` in 1: Avalon wait.
- `writedata` out 32: lane-steered store data.
- `byteenable` out 4: active lanes.
- `readdata` in 32: Avalon read data.

## Operation
- The FSM has three states: IDLE, ACCESS and DONE.
- **IDLE, `req_i`=1**
  - Latch the request and go to ACCESS.
  - With `ALIGN_CHECK_EN` and a misaligned request, go directly to DONE with the error set instead.
- **ACCESS**
  - Drive `address` = {addr[ADDR_WIDTH-1:2],2'b00}.
  - Drive `read` = !wen or `write` = wen.
  - Hold all bus outputs stable while `waitrequest`=1.
  - On `read|write` with `waitrequest`=0, capture `readdata` and go to DONE.
- **DONE**
  - Assert `done_o` (and `err_o` if failed) and go to IDLE.
  - `req_i` is ignored in this state.
- **Lane steering**, with `a` = addr[1:0]:
  - Byte: `byteenable` = 4'b0001<<a; `writedata` = wdata[7:0]<<8a.
  - Half: `byteenable` = 4'b0011<<{a[1],1'b0}; `writedata` = wdata[15:0]<<16a[1].
  - Word: `byteenable` = 4'b1111; `writedata` = wdata.
- **Load extraction**
  - Select the same lane from `readdata` and extend per `signed_i` into `rdata_o`.
  - On an error, or on a store, `rdata_o` = 0.
- **Timeout**
  - The counter (width $clog2(TIMEOUT+1)) counts ACCESS cycles with `waitrequest`=1.
  - At count==TIMEOUT: drop the strobes, go to DONE, set the error.
  - The counter clears on entry to ACCESS.
- **`stall_o`** = (state==ACCESS) | (state==IDLE & `req_i`). It is low in DONE, so the core advances on `done_o`.
- **Reset (async, any state)**
  - The FSM returns to IDLE.
  - All outputs go to 0: `read`, `write`, `done_o`, `err_o`, `stall_o` (apart from its combinational `req_i` term), `rdata_o`, `byteenable`, `address`, `writedata`.
  - A bus transfer in flight is abandoned immediately.

## Timing
- All bus outputs are registered; nothing is combinational from `req_i` to the bus.
- A request in IDLE at cycle N produces bus strobes in cycle N+1.
- A zero-wait slave (`waitrequest`=0 at N+1) gives `done_o` and `rdata_o` valid at N+2.
- With k wait cycles: `done_o` at N+2+k. Minimum occupancy is 3 cycles per access.
- `rdata_o` holds its value until the next completion.
- Timeout: strobes run from N+1 to N+TIMEOUT; `done_o`+`err_o` at N+TIMEOUT+2 (strobes drop after the cycle where the count equals TIMEOUT).
- A `waitrequest` fall in the same cycle the count reaches TIMEOUT counts as success.
- A misaligned access under `ALIGN_CHECK_EN` gives `done_o`+`err_o` at N+1, with no strobes.

## Configuration
- `MEM_BUS_ALIGN_CHECK_EN` defined:
  - Half with addr[0]=1 or word with addr[1:0]≠0 is rejected.
  - The rejection issues no bus cycle and raises `err_o`, so the core can raise an address exception.
- `MEM_BUS_ALIGN_CHECK_EN` undefined:
  - Low address bits are forced to alignment (half ignores a[0]; word ignores a[1:0]).
  - `err_o` then arises only from the timeout.

## Test plan
- **Zero-wait word load:** addr 0x100, slave returns 0xDEADBEEF with `waitrequest`=0. Expect `read`=1 and `byteenable`=1111 at N+1; `done_o`=1 and `rdata_o`=0xDEADBEEF at N+2; `err_o`=0.
- **Signed byte load with 3 wait cycles:** addr 0x103, `readdata`=0x80112233, `signed_i`=1. Expect `byteenable`=1000, bus outputs stable for 3 cycles, `rdata_o`=0xFFFFFF80 at N+5. Repeat with `signed_i`=0: expect `rdata_o`=0x00000080.
- **Half store:** addr 0x202, `wdata_i`=0x0000ABCD. Expect `address`=0x200, `byteenable`=1100, `writedata`=0xABCD0000, `write`=1, `rdata_o`=0.
- **Timeout:** TIMEOUT=4, `waitrequest` held at 1. Expect strobes for 4 cycles, then `done_o`=`err_o`=1, `rdata_o`=0, core unstalled.
- **Misaligned word at 0x101:**
  - With the macro: `done_o`+`err_o` at N+1, `read` never asserted.
  - Without the macro: `address`=0x100, `byteenable`=1111, normal completion.
- **Reset mid-ACCESS** (`waitrequest`=1): `read` and `stall_o` deassert without waiting for a clock edge. After release, a new request completes normally.

Source files
------------

// File: rtl/mem_bus_master.sv
// Avalon-MM master for one load/store at a time: lane steering, load extension, bounded wait.
// Optional feature macro: MEM_BUS_ALIGN_CHECK_EN (reject misaligned half/word requests).
module mem_bus_master #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_i,
  input  logic                  wen_i,
  input  logic [1:0]            size_i,
  input  logic                  signed_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [31:0]           wdata_i,
  output logic [31:0]           rdata_o,
  output logic                  stall_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [ADDR_WIDTH-1:0] address,
  output logic                  write,
  output logic                  read,
  input  logic                  waitrequest,
  output logic [31:0]           writedata,
  output logic [3:0]            byteenable,
  input  logic [31:0]           readdata
);
  localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  state_t                r_state, w_state_n;
  logic                  r_wen, w_wen_n;
  logic [1:0]            r_size, w_size_n;
  logic                  r_sgn, w_sgn_n;
  logic [1:0]            r_lane, w_lane_n;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_n;
  logic [3:0]            r_be, w_be_n;
  logic [31:0]           r_wd, w_wd_n;
  logic                  r_read, w_read_n;
  logic                  r_write, w_write_n;
  logic [CNT_W-1:0]      r_cnt, w_cnt_n;
  logic                  r_done, w_done_n;
  logic                  r_err, w_err_n;
  logic [31:0]           r_rdata, w_rdata_n;

  logic [3:0]            w_be_req;
  logic [31:0]           w_wd_req;
  logic                  w_misalign;
  logic [7:0]            w_rd_byte;
  logic [15:0]           w_rd_half;
  logic [31:0]           w_load;
  logic [CNT_W-1:0]      w_cnt_inc;

`ifdef MEM_BUS_ALIGN_CHECK_EN
  assign w_misalign = ((size_i == 2'b01) & addr_i[0]) | (size_i[1] & (|addr_i[1:0]));
`else
  assign w_misalign = 1'b0;
`endif

  // Lane steering of the incoming request; low address bits beyond the size are ignored.
  always_comb begin
    w_be_req = 4'b1111;
    w_wd_req = wdata_i;
    case (size_i)
      2'b00: begin
        w_be_req = 4'b0001 << addr_i[1:0];
        w_wd_req = {24'b0, wdata_i[7:0]} << {addr_i[1:0], 3'b000};
      end
      2'b01: begin
        w_be_req = 4'b0011 << {addr_i[1], 1'b0};
        w_wd_req = {16'b0, wdata_i[15:0]} << {addr_i[1], 4'b0000};
      end
      default: ;
    endcase
  end

  assign w_rd_byte = readdata[{r_lane, 3'b000} +: 8];
  assign w_rd_half = readdata[{r_lane[1], 4'b0000} +: 16];

  // Extract the addressed lane from readdata and extend it.
  always_comb begin
    w_load = readdata;
    case (r_size)
      2'b00:   w_load = {{24{r_sgn & w_rd_byte[7]}}, w_rd_byte};
      2'b01:   w_load = {{16{r_sgn & w_rd_half[15]}}, w_rd_half};
      default: ;
    endcase
  end

  assign w_cnt_inc = r_cnt + CNT_W'(1);

  // Next-state and next-output logic.
  always_comb begin
    w_state_n = r_state;
    w_wen_n   = r_wen;
    w_size_n  = r_size;
    w_sgn_n   = r_sgn;
    w_lane_n  = r_lane;
    w_addr_n  = r_addr;
    w_be_n    = r_be;
    w_wd_n    = r_wd;
    w_read_n  = r_read;
    w_write_n = r_write;
    w_cnt_n   = r_cnt;
    w_done_n  = 1'b0;
    w_err_n   = 1'b0;
    w_rdata_n = r_rdata;
    case (r_state)
      S_IDLE: begin
        if (req_i) begin
          w_wen_n  = wen_i;
          w_size_n = size_i;
          w_sgn_n  = signed_i;
          w_lane_n = addr_i[1:0];
          if (w_misalign) begin
            w_state_n = S_DONE;
            w_done_n  = 1'b1;
            w_err_n   = 1'b1;
            w_rdata_n = '0;
          end else begin
            w_state_n = S_ACCESS;
            w_addr_n  = {addr_i[ADDR_WIDTH-1:2], 2'b00};
            w_be_n    = w_be_req;
            w_wd_n    = w_wd_req;
            w_read_n  = ~wen_i;
            w_write_n = wen_i;
            w_cnt_n   = '0;
          end
        end
      end
      S_ACCESS: begin
        if (r_read | r_write) begin
          if (!waitrequest) begin
            w_state_n = S_DONE;
            w_read_n  = 1'b0;
            w_write_n = 1'b0;
            w_done_n  = 1'b1;
            w_rdata_n = r_wen ? 32'd0 : w_load;
          end else if (TIMEOUT != 0) begin
            w_cnt_n = w_cnt_inc;
            // Last permitted wait cycle: strobes drop, abort follows next cycle.
            if (w_cnt_inc == CNT_W'(TIMEOUT)) begin
              w_read_n  = 1'b0;
              w_write_n = 1'b0;
            end
          end
        end else begin
          w_state_n = S_DONE;
          w_done_n  = 1'b1;
          w_err_n   = 1'b1;
          w_rdata_n = '0;
        end
      end
      S_DONE: w_state_n = S_IDLE;
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_wen   <= 1'b0;
      r_size  <= 2'b00;
      r_sgn   <= 1'b0;
      r_lane  <= 2'b00;
      r_addr  <= '0;
      r_be    <= 4'b0000;
      r_wd    <= 32'd0;
      r_read  <= 1'b0;
      r_write <= 1'b0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= 32'd0;
    end else begin
      r_state <= w_state_n;
      r_wen   <= w_wen_n;
      r_size  <= w_size_n;
      r_sgn   <= w_sgn_n;
      r_lane  <= w_lane_n;
      r_addr  <= w_addr_n;
      r_be    <= w_be_n;
      r_wd    <= w_wd_n;
      r_read  <= w_read_n;
      r_write <= w_write_n;
      r_cnt   <= w_cnt_n;
      r_done  <= w_done_n;
      r_err   <= w_err_n;
      r_rdata <= w_rdata_n;
    end
  end

  assign stall_o    = (r_state == S_ACCESS) | ((r_state == S_IDLE) & req_i);
  assign done_o     = r_done;
  assign err_o      = r_err;
  assign rdata_o    = r_rdata;
  assign address    = r_addr;
  assign read       = r_read;
  assign write      = r_write;
  assign byteenable = r_be;
  assign writedata  = r_wd;

endmodule

// File: tb/tb_mem_bus_master.sv
// Randomized scoreboard bench for mem_bus_master against an arithmetic reference model.
module tb_mem_bus_master;
  localparam int unsigned AW = 32;
  localparam int unsigned TO = 4;
`ifdef MEM_BUS_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    logic        rd_s;
    logic        wr_s;
    logic [31:0] rdata;
    logic        err;
    int          strobes;
    int          latency;
    int          k;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_i, wen_i, signed_i;
  logic [1:0]    size_i;
  logic [AW-1:0] addr_i;
  logic [31:0]   wdata_i, rdata_o;
  logic          stall_o, done_o, err_o;
  logic [AW-1:0] address;
  logic          write, read;
  logic          waitrequest = 1'b1;
  logic [31:0]   writedata, readdata;
  logic [3:0]    byteenable;

  exp_t bus_q[$];
  exp_t done_q[$];
  exp_t cur, dexp, rst_e;
  int   checks = 0;
  int   errors = 0;
  int   mon_j = 0;
  bit   in_txn = 1'b0;

  mem_bus_master #(.ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req_i(req_i), .wen_i(wen_i), .size_i(size_i),
    .signed_i(signed_i), .addr_i(addr_i), .wdata_i(wdata_i), .rdata_o(rdata_o),
    .stall_o(stall_o), .done_o(done_o), .err_o(err_o), .address(address),
    .write(write), .read(read), .waitrequest(waitrequest), .writedata(writedata),
    .byteenable(byteenable), .readdata(readdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: sizes in bytes, lane offset by integer division, extension by masking.
  function automatic exp_t model(input logic wen, input logic [1:0] size, input logic sgn,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] rd, input int k);
    exp_t e;
    int sz, a, off;
    logic [31:0] mask, v;
    bit mis;
    sz   = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    a    = int'(addr % 32'd4);
    off  = (a / sz) * sz;
    mis  = ALIGN && ((a % sz) != 0);
    mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
    e.addr = addr - 32'(a);
    e.be   = 4'(((1 << sz) - 1) << off);
    e.wd   = (wdata & mask) << (8 * off);
    v = (rd >> (8 * off)) & mask;
    if (sgn && v[8 * sz - 1]) v = v | ~mask;
    e.rd_s    = !wen;
    e.wr_s    = wen;
    e.k       = k;
    e.err     = mis || (k >= int'(TO));
    e.rdata   = (e.err || wen) ? 32'd0 : v;
    e.strobes = mis ? 0 : ((k >= int'(TO)) ? int'(TO) : k + 1);
    e.latency = mis ? 1 : ((k >= int'(TO)) ? int'(TO) + 2 : k + 2);
    return e;
  endfunction

  // Slave model plus monitor: answers strobes with k wait cycles and scores completions.
  always @(negedge clk) begin
    if (reset) begin
      in_txn = 1'b0;
      mon_j = 0;
      waitrequest = 1'b1;
    end else begin
      if (read || write) begin
        if (!in_txn) begin
          if (bus_q.size() == 0) chk("unexpected_strobe", 64'd1, 64'd0);
          else cur = bus_q.pop_front();
          in_txn = 1'b1;
          mon_j = 0;
        end
        chk("bus_ctrl", {26'd0, address, byteenable, read, write},
            {26'd0, cur.addr, cur.be, cur.rd_s, cur.wr_s});
        if (write) chk("bus_wdata", 64'(writedata), 64'(cur.wd));
        waitrequest = (mon_j < cur.k);
        mon_j++;
      end else begin
        waitrequest = 1'($urandom);
      end
      if (done_o) begin
        if (done_q.size() == 0) chk("unexpected_done", 64'd1, 64'd0);
        else begin
          dexp = done_q.pop_front();
          chk("rdata", 64'(rdata_o), 64'(dexp.rdata));
          chk("err", 64'(err_o), 64'(dexp.err));
          chk("strobe_cycles", 64'(mon_j), 64'(dexp.strobes));
        end
        in_txn = 1'b0;
        mon_j = 0;
      end
    end
  end

  // Issue one request at the current negedge and wait for its completion.
  task automatic do_txn(input logic wen, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rd, input int k);
    exp_t e;
    int lat;
    e = model(wen, size, sgn, addr, wdata, rd, k);
    if (e.strobes > 0) bus_q.push_back(e);
    done_q.push_back(e);
    readdata = rd;
    req_i = 1'b1; wen_i = wen; size_i = size; signed_i = sgn; addr_i = addr; wdata_i = wdata;
    #1 chk("stall_req", 64'(stall_o), 64'd1);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        req_i = 1'b0; wen_i = 1'($urandom); size_i = 2'($urandom);
        signed_i = 1'($urandom); addr_i = $urandom; wdata_i = $urandom;
        if (e.latency > 1) chk("stall_access", 64'(stall_o), 64'd1);
      end
    end while (!done_o && lat < 200);
    chk("latency", 64'(lat), 64'(e.latency));
    chk("stall_done", 64'(stall_o), 64'd0);
    readdata = $urandom;
    @(negedge clk);
    chk("rdata_hold", 64'(rdata_o), 64'(e.rdata));
    chk("idle_quiet", {61'd0, done_o, read, write}, 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; req_i = 1'b0; wen_i = 1'b0; size_i = 2'b00; signed_i = 1'b0;
    addr_i = '0; wdata_i = '0; readdata = '0;
    @(negedge clk);
    chk("reset_ctrl", {57'd0, read, write, done_o, err_o, stall_o, byteenable[1:0]}, 64'd0);
    chk("reset_be_rdata", {28'd0, byteenable, rdata_o}, 64'd0);
    chk("reset_addr_wdata", {address, writedata}, 64'd0);
    @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);

    do_txn(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 0);
    do_txn(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 32'h80112233, 3);
    do_txn(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 32'h80112233, 3);
    do_txn(1'b1, 2'b01, 1'b0, 32'h202, 32'h0000ABCD, 32'h5555AAAA, 0);
    do_txn(1'b0, 2'b10, 1'b0, 32'h300, 32'h0, 32'h11111111, 50);
    do_txn(1'b1, 2'b10, 1'b0, 32'h304, 32'hCAFEF00D, 32'h0, int'(TO) - 1);
    do_txn(1'b0, 2'b01, 1'b1, 32'h306, 32'h0, 32'h9234ABCD, int'(TO));
    do_txn(1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 32'h01020304, 0);
    do_txn(1'b0, 2'b11, 1'b1, 32'h10A, 32'h0, 32'hF0E0D0C0, 1);

    // Reset while the slave is still holding waitrequest.
    rst_e = model(1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 32'h12345678, 1000);
    bus_q.push_back(rst_e);
    readdata = 32'h12345678;
    req_i = 1'b1; wen_i = 1'b0; size_i = 2'b10; signed_i = 1'b0; addr_i = 32'h400;
    @(negedge clk);
    req_i = 1'b0;
    @(negedge clk);
    chk("pre_reset_read", 64'(read), 64'd1);
    #2 reset = 1'b1;
    #1 chk("async_reset", {61'd0, read, stall_o, done_o}, 64'd0);
    @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    do_txn(1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 32'h0BADF00D, 2);

    for (int i = 0; i < 150; i++) begin
      int r, k;
      r = int'($urandom_range(0, 9));
      if (r < 5) k = int'($urandom_range(0, 2));
      else if (r < 7) k = int'(TO) - 1;
      else if (r < 8) k = int'(TO);
      else k = int'($urandom_range(TO + 1, TO + 5));
      do_txn(1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom, $urandom, k);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    chk("queues_drained", 64'(bus_q.size() + done_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
